// File: rtl/k2red_pkg.sv
// Shared definitions for the k2red block family: FSM state encoding and the
// default operand/modulus width.
package k2red_pkg;

    localparam int K2RED_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } k2red_state_e;

endpackage : k2red_pkg

// File: rtl/k2red_blakley_step.sv
// One MSB-first Blakley modular-multiply iteration: acc_next = (2*acc + k_bit*X) mod Q,
// assuming acc, X < Q. Intermediates carry one extra bit so 2*acc and t+X cannot overflow.
module k2red_blakley_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Q,
    input  logic         k_bit,
    output logic [W-1:0] acc_next
);

    logic [W:0] q_ext;
    logic [W:0] t_dbl;
    logic [W:0] t_red1;
    logic [W:0] t_add;
    logic [W:0] t_red2;

    always_comb begin
        q_ext  = {1'b0, Q};
        t_dbl  = {acc, 1'b0};
        t_red1 = (t_dbl >= q_ext) ? (t_dbl - q_ext) : t_dbl;
        t_add  = k_bit ? (t_red1 + {1'b0, X}) : t_red1;
        t_red2 = (t_add >= q_ext) ? (t_add - q_ext) : t_add;
    end

    assign acc_next = t_red2[W-1:0];

endmodule : k2red_blakley_step

// File: rtl/k2red_unscale.sv
// Removes the k^2 factor left by k2red: Y = (X*KINV) mod Q, computed serially over
// the bits of KINV (one Blakley step per cycle) behind a valid/ready handshake.
module k2red_unscale
    import k2red_pkg::*;
#(
    parameter int W = K2RED_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X,
    input  logic [W-1:0] KINV,
    input  logic [W-1:0] Q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    k2red_state_e  state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  kinv_q, kinv_d;
    logic [W-1:0]  mod_q, mod_d;
    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  acc_next;

    k2red_blakley_step #(.W(W)) u_step (
        .acc      (acc_q),
        .X        (x_q),
        .Q        (mod_q),
        .k_bit    (kinv_q[cnt_q]),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        kinv_d  = kinv_q;
        mod_d   = mod_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = X;
                    kinv_d  = KINV;
                    mod_d   = Q;
                    acc_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                if (cnt_q == '0) begin
                    y_d     = acc_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            kinv_q  <= '0;
            mod_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            kinv_q  <= kinv_d;
            mod_q   <= mod_d;
            y_q     <= y_d;
        end
    end

    // in_ready stays low while reset is held so nothing is offered to a block in reset.
    assign in_ready  = (state_q == IDLE) && rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Y         = y_q;

endmodule : k2red_unscale

// File: tb/tb_k2red_unscale.sv
// Directed and random checks of k2red_unscale at W=16 with the Proth modulus 12289.
module tb_k2red_unscale;

    localparam int          W      = 16;
    localparam logic [15:0] QMOD   = 16'd12289;
    localparam logic [15:0] KINV9  = 16'd2731;
    localparam int          TMO    = 100;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  X;
    logic [W-1:0]  KINV;
    logic [W-1:0]  Q;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Y;
    logic          busy;

    int n_tests;
    int n_fail;

    k2red_unscale #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .KINV      (KINV),
        .Q         (Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one operand set, scramble the inputs after accept, and wait for out_valid.
    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] kv,
                          output logic [W-1:0] yv, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < TMO) begin
            @(posedge clk); #1; w++;
        end
        if (w >= TMO) chk("in_ready_timeout", w, 0);
        X = xv; KINV = kv; Q = QMOD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        X = 16'(~xv); KINV = 16'(~kv); Q = 16'd7;
        lat = 0;
        while (!out_valid && lat < TMO) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= TMO) chk("out_valid_timeout", lat, W);
        yv = Y;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] y;
        logic [W-1:0] xr, kr;
        longint       gold;
        int           lat;

        n_tests = 0; n_fail = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        X = '0; KINV = '0; Q = QMOD;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y", Y, 0);
        #10 rst = 1'b1;
        #1;
        chk("rst_rel_in_ready", in_ready, 1);
        chk("rst_rel_out_valid", out_valid, 0);

        // 9 * 9^-1 = 1, latency W
        run_op(16'd9, KINV9, y, lat);
        chk("inv9_y", y, 1);
        chk("inv9_latency", lat, 16);
        chk("inv9_busy_done", busy, 1);
        release_out();
        chk("inv9_idle", in_ready, 1);

        run_op(16'd0, KINV9, y, lat);
        chk("zero_y", y, 0);
        release_out();

        run_op(16'd12288, 16'd1, y, lat);
        chk("qm1_times1_y", y, 12288);
        release_out();

        run_op(16'd12288, 16'd12288, y, lat);
        chk("neg1_sq_y", y, 1);
        release_out();

        // DONE hold with out_ready low and in_valid pulses ignored
        run_op(16'd9, KINV9, y, lat);
        chk("hold_y0", y, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; X = 16'd123; KINV = 16'd456; Q = QMOD;
            @(posedge clk); #1;
            chk("hold_y", Y, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        release_out();
        chk("hold_release_idle", in_ready, 1);
        chk("hold_release_busy", busy, 0);
        chk("hold_release_out_valid", out_valid, 0);

        // Reset in the middle of RUN
        X = 16'd9; KINV = KINV9; Q = QMOD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_run_busy", busy, 1);
        rst = 1'b0;
        #2;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_y", Y, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rel_in_ready", in_ready, 1);
        chk("mid_rel_out_valid", out_valid, 0);
        run_op(16'd9, KINV9, y, lat);
        chk("after_rst_y", y, 1);
        chk("after_rst_latency", lat, 16);
        release_out();

        // Back-to-back random operands against a golden model
        for (int n = 0; n < 1000; n++) begin
            xr   = 16'($urandom_range(0, 12288));
            kr   = 16'($urandom_range(0, 12288));
            gold = (longint'(xr) * longint'(kr)) % 64'd12289;
            run_op(xr, kr, y, lat);
            chk($sformatf("rand%0d_y", n), y, gold);
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_k2red_unscale

// File: doc/k2red_unscale.md
K2RED_UNSCALE -- requirements
Module: k2red_unscale

Interface
REQ-001 The block SHALL have parameter W, default 64, giving the operand and modulus width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand set present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-006 The block SHALL have port X, input, W bits: K2RED-domain value, X < Q.
REQ-007 The block SHALL have port KINV, input, W bits: precomputed k^-2 mod Q, KINV < Q.
REQ-008 The block SHALL have port Q, input, W bits: Proth modulus k*2^m+1, odd.
REQ-009 The block SHALL have port out_valid, output, 1 bit: Y holds a finished result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts Y.
REQ-011 The block SHALL have port Y, output, W bits: the result (X*KINV) mod Q, which removes the k^2 factor introduced by k2red.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, the block SHALL drive in_ready=1 and out_valid=0; in RUN, in_ready=0 and out_valid=0; in DONE, in_ready=0 and out_valid=1.
REQ-015 Input accept SHALL occur on an edge with in_valid=1 and in_ready=1; X, KINV and Q SHALL be latched internally, acc cleared to 0, bit counter loaded with W-1, and the FSM SHALL move to RUN.
REQ-016 Input changes after accept SHALL NOT affect the result.
REQ-017 Each RUN edge SHALL perform one MSB-first Blakley iteration using bit i=counter of latched KINV: t=2*acc; if t>=Q then t=t-Q; if KINV[i]=1 then t=t+X; if t>=Q then t=t-Q; acc=t.
REQ-018 Intermediate t SHALL be W+1 bits wide, and acc SHALL remain in [0,Q) after every iteration.
REQ-019 On the RUN edge with counter=0, the FSM SHALL go to DONE with Y=acc; otherwise counter decrements.
REQ-020 Latency SHALL be exactly W edges from the accept edge to out_valid=1.
REQ-021 In DONE, Y SHALL be held stable while out_ready=0.
REQ-022 On an edge with out_ready=1 in DONE, the FSM SHALL return to IDLE; next accept is possible on the following edge, giving an initiation interval of W+2 cycles minimum.
REQ-023 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-024 Behaviour for X>=Q, KINV>=Q or even Q is undefined; the block SHALL not hang, and SHALL return to IDLE through the normal sequence.

Reset
REQ-025 While rst=0, the block SHALL asynchronously force: state=IDLE, acc=0, counter=0, latched operands=0, Y=0, out_valid=0, busy=0; in_ready SHALL be 1 once rst=1.
REQ-026 A reset during RUN or DONE SHALL abort the operation with no result emitted, and the first accept after release SHALL compute correctly.

Structure
REQ-027 The state encoding (IDLE=0, RUN=1, DONE=2) and the default W SHALL reside in shared package k2red_pkg, reused by the other k2red blocks.
REQ-028 The single-iteration combinational datapath (double, conditional add, two conditional subtracts) SHALL be sub-module k2red_blakley_step with inputs acc, X, Q, bit and output acc_next.
REQ-029 The FSM, counter and handshake SHALL live in k2red_unscale.

Verification (bench W=16, Q=12289=3*2^12+1, KINV=2731=9^-1 mod Q)
REQ-030 The bench SHALL apply X=9, KINV=2731 and require Y=1, with out_valid rising exactly 16 edges after accept.
REQ-031 The bench SHALL apply X=0, KINV=2731 and require Y=0; it SHALL apply X=12288, KINV=1 and require Y=12288.
REQ-032 The bench SHALL apply X=12288, KINV=12288 and require Y=1 (the (-1)*(-1) case, exercising both subtract paths).
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE and require Y stable, in_ready=0, and in_valid pulses ignored; after out_ready=1, the FSM SHALL be in IDLE on the next cycle.
REQ-034 The bench SHALL drive rst=0 at RUN iteration 7 and require out_valid=0 and in_ready=1 after release; the bench SHALL then apply X=9 and require Y=1.
REQ-035 The bench SHALL apply 1000 random X,KINV < Q back-to-back and require each Y to equal the golden (X*KINV) mod Q, in order.
